// File: rtl/alu_op_sequencer_pkg.sv
// Opcode set shared with the registered ALU, plus the
// opcode classification helpers used by the sequencer.
package alu_op_sequencer_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_arith_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Collects A, B and Op from one valid/ready word stream, drives the
// registered ALU, waits out its latency and returns the captured result.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int N       = 4,
    parameter int NSel    = 6,
    parameter int DATA_W  = 8,
    parameter int ALU_LAT = 1
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [N-1:0]      o_alu_A,
    output logic [N-1:0]      o_alu_B,
    output logic [NSel-1:0]   o_alu_Op,
    input  logic [N-1:0]      i_alu_Result,
    input  logic              i_alu_overflow,
    output logic [N-1:0]      o_result,
    output logic              o_overflow,
    output logic              o_bad_op,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_OP,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;

    logic            w_xfer;
    logic            w_cnt_done;
    logic            w_capture;
    logic [OP_W-1:0] w_op;
    logic            w_unused;

    assign w_xfer     = i_valid & o_ready;
    assign w_cnt_done = (r_cnt == CNT_W'(ALU_LAT));
    assign w_capture  = (r_state == S_EXEC) && w_cnt_done;
    assign w_op       = OP_W'(o_alu_Op);
    // Operand/opcode words may carry extra high bits that are dropped.
    assign w_unused   = ^i_data;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_LOAD_A;
            r_cnt       <= '0;
            o_ready     <= 1'b0;
            o_busy      <= 1'b0;
            o_res_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_LOAD_A: begin
                    o_ready <= 1'b1;
                    if (w_xfer) begin
                        r_state <= S_LOAD_B;
                        o_busy  <= 1'b1;
                    end
                end
                S_LOAD_B: begin
                    if (w_xfer) r_state <= S_LOAD_OP;
                end
                S_LOAD_OP: begin
                    if (w_xfer) begin
                        r_state <= S_EXEC;
                        o_ready <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_EXEC: begin
                    if (w_cnt_done) begin
                        r_state     <= S_RESP;
                        o_res_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_res_ready) begin
                        r_state     <= S_LOAD_A;
                        o_res_valid <= 1'b0;
                        o_ready     <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_LOAD_A;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_a        <= '0;
            r_b        <= '0;
            o_alu_A    <= '0;
            o_alu_B    <= '0;
            o_alu_Op   <= '0;
            o_result   <= '0;
            o_overflow <= 1'b0;
            o_bad_op   <= 1'b0;
        end else begin
            if (w_xfer && r_state == S_LOAD_A) r_a <= i_data[N-1:0];
            if (w_xfer && r_state == S_LOAD_B) r_b <= i_data[N-1:0];
            // Operands and op reach the ALU together on the Op accept.
            if (w_xfer && r_state == S_LOAD_OP) begin
                o_alu_A  <= r_a;
                o_alu_B  <= r_b;
                o_alu_Op <= i_data[NSel-1:0];
            end
            if (w_capture) begin
                o_result   <= i_alu_Result;
                o_overflow <= i_alu_overflow & is_arith_op(w_op);
                o_bad_op   <= ~is_valid_op(w_op);
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized checks of the ALU op sequencer against a
// behavioural model, with a registered ALU responder on the ALU side.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic       i_clock;
    logic       i_reset_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] o_alu_A;
    logic [3:0] o_alu_B;
    logic [5:0] o_alu_Op;
    logic [3:0] alu_res;
    logic       alu_ovf;
    logic [3:0] o_result;
    logic       o_overflow;
    logic       o_bad_op;
    logic       o_res_valid;
    logic       i_res_ready;
    logic       o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
                            OP_XOR, OP_SRA, OP_SRL, OP_NOR};

    alu_op_sequencer #(
        .N(4), .NSel(6), .DATA_W(8), .ALU_LAT(1)
    ) dut (
        .i_clock        (i_clock),
        .i_reset_n      (i_reset_n),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_alu_A        (o_alu_A),
        .o_alu_B        (o_alu_B),
        .o_alu_Op       (o_alu_Op),
        .i_alu_Result   (alu_res),
        .i_alu_overflow (alu_ovf),
        .o_result       (o_result),
        .o_overflow     (o_overflow),
        .o_bad_op       (o_bad_op),
        .o_res_valid    (o_res_valid),
        .i_res_ready    (i_res_ready),
        .o_busy         (o_busy)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // ALU responder; its flag follows the adder for every valid op so
    // the sequencer's own ADD/SUB gating is what decides o_overflow.
    function automatic logic [4:0] alu_resp(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [5:0] op);
        logic [3:0] s;
        logic [3:0] d;
        logic [3:0] r;
        logic       ova;
        s   = a + b;
        d   = a - b;
        ova = (a[3] == b[3]) && (s[3] != a[3]);
        case (op)
            OP_ADD: return {ova, s};
            OP_SUB: return {(a[3] != b[3]) && (d[3] != a[3]), d};
            OP_AND: return {ova, a & b};
            OP_OR:  return {ova, a | b};
            OP_XOR: return {ova, a ^ b};
            OP_NOR: return {ova, ~(a | b)};
            OP_SRA: begin
                r = $signed(a) >>> b;
                return {ova, r};
            end
            OP_SRL: return {ova, a >> b};
            default: return 5'b0;
        endcase
    endfunction

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            alu_res <= '0;
            alu_ovf <= 1'b0;
        end else begin
            {alu_ovf, alu_res} <= alu_resp(o_alu_A, o_alu_B, o_alu_Op);
        end
    end

    // Reference: {bad_op, overflow, result} from integer arithmetic.
    function automatic logic [5:0] model(input int a, input int b,
                                         input logic [5:0] op);
        int   sa;
        int   sb;
        int   r;
        logic ov;
        logic bad;
        sa  = (a > 7) ? a - 16 : a;
        sb  = (b > 7) ? b - 16 : b;
        r   = 0;
        ov  = 1'b0;
        bad = 1'b0;
        case (op)
            OP_ADD: begin r = sa + sb; ov = (r > 7) || (r < -8); end
            OP_SUB: begin r = sa - sb; ov = (r > 7) || (r < -8); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOR: r = ~(a | b);
            OP_SRA: r = sa >>> b;
            OP_SRL: r = a >> b;
            default: bad = 1'b1;
        endcase
        r = r & 15;
        return {bad, ov, r[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        bit took;
        took   = 1'b0;
        i_data  = w;
        i_valid = 1'b1;
        for (int k = 0; k < 20 && !took; k++) begin
            took = o_ready;
            tick();
        end
        i_valid = 1'b0;
        if (!took) begin
            n_cmp++;
            n_bad++;
            $error("FAIL send_timeout: observed no accept expected accept");
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [5:0] op);
        logic [3:0] hi_a;
        logic [3:0] hi_b;
        logic [1:0] hi_o;
        hi_a = 4'($urandom_range(0, 15));
        hi_b = 4'($urandom_range(0, 15));
        hi_o = 2'($urandom_range(0, 3));
        send({hi_a, a});
        send({hi_b, b});
        send({hi_o, op});
        check("alu_A", o_alu_A, a);
        check("alu_B", o_alu_B, b);
        check("alu_Op", o_alu_Op, op);
        check("ready_exec", o_ready, 0);
    endtask

    task automatic collect(input logic [3:0] a, input logic [3:0] b,
                           input logic [5:0] op);
        logic [5:0] e;
        int k;
        e = model(a, b, op);
        k = 0;
        while (!o_res_valid && k < 10) begin
            tick();
            k++;
        end
        check("latency", k, 2);
        check("result", o_result, e[3:0]);
        check("overflow", o_overflow, e[4]);
        check("bad_op", o_bad_op, e[5]);
        check("busy_resp", o_busy, 1);
        check("ready_resp", o_ready, 0);
    endtask

    task automatic release_res(input int d);
        for (int k = 0; k < d; k++) begin
            tick();
            check("hold_valid", o_res_valid, 1);
        end
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        check("valid_clr", o_res_valid, 0);
        check("busy_clr", o_busy, 0);
        check("ready_back", o_ready, 1);
    endtask

    task automatic run_cmd(input logic [3:0] a, input logic [3:0] b,
                           input logic [5:0] op, input int d);
        issue(a, b, op);
        collect(a, b, op);
        release_res(d);
    endtask

    initial begin
        logic [3:0] held;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [5:0] rop;

        i_reset_n   = 1'b0;
        i_data      = '0;
        i_valid     = 1'b0;
        i_res_ready = 1'b0;
        repeat (3) tick();
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_res_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_data", {o_alu_A, o_alu_B, o_alu_Op, o_result,
                           o_overflow, o_bad_op}, 0);
        i_reset_n = 1'b1;
        tick();
        check("post_rst_ready", o_ready, 1);

        run_cmd(4'd3, 4'd4, OP_ADD, 0);
        run_cmd(4'd7, 4'd1, OP_ADD, 1);
        run_cmd(4'd9, 4'd3, OP_AND, 0);
        run_cmd(4'b1000, 4'd1, OP_SRA, 0);
        run_cmd(4'b1000, 4'd1, OP_SRL, 2);
        run_cmd(4'd6, 4'd5, 6'b111111, 0);

        // Backpressure with a word waiting on the input.
        issue(4'd2, 4'd6, OP_ADD);
        collect(4'd2, 4'd6, OP_ADD);
        held        = o_result;
        i_data      = 8'hA5;
        i_valid     = 1'b1;
        repeat (5) begin
            tick();
            check("bp_valid", o_res_valid, 1);
            check("bp_result", o_result, held);
            check("bp_ready", o_ready, 0);
        end
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        check("bp_release", o_res_valid, 0);
        send(8'hA5);
        send(8'h03);
        send({2'b01, OP_SUB});
        collect(4'd5, 4'd3, OP_SUB);
        release_res(0);

        // Reset while the command is in EXEC.
        issue(4'd6, 4'd2, OP_ADD);
        #3;
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {o_ready, o_res_valid, o_busy}, 0);
        check("mid_rst_data", {o_alu_A, o_alu_B, o_alu_Op, o_result,
                               o_overflow, o_bad_op}, 0);
        tick();
        i_reset_n = 1'b1;
        tick();
        check("mid_rst_ready", o_ready, 1);
        check("mid_rst_busy", o_busy, 0);
        run_cmd(4'd5, 4'd3, OP_SUB, 0);

        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rop = 6'($urandom_range(0, 63));
            else                           rop = ops[$urandom_range(0, 7)];
            run_cmd(ra, rb, rop, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
